i2c_regbank_arbiter: RTL and testbench
======================================

# i2c_regbank_arbiter

Dual-port 8-bit register bank shared between the I2C slave's register-file strobe interface and a local fabric requester. The I2C port is zero-wait and always wins. The local port uses a req/ack handshake and is deferred on collisions. The bank holds a read-only ID register, a collision counter, and general RW configuration registers that are broadcast flat to the rest of the FPGA design.

## Interface

**Parameters**

- `NUM_REGS`, default 16: number of implemented registers. Legal range 3..256. Addresses `>= NUM_REGS` are unmapped.
- `ID_VALUE`, default `8'hA5`: constant returned by register 0x00.

**Ports**

- `clk` in 1: 100 MHz system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `i2c_addr` in 8: register address from the I2C slave.
- `i2c_wdata` in 8: write data from the I2C slave.
- `i2c_wr` in 1: single-cycle write strobe.
- `i2c_rd` in 1: single-cycle read strobe. Informational only; reads are combinational.
- `i2c_rdata` out 8: read data for `i2c_addr`, combinational.
- `loc_req` in 1: local access request, level, held until ack.
- `loc_we` in 1: local write (1) or read (0); qualified by `loc_req`.
- `loc_addr` in 8: local register address.
- `loc_wdata` in 8: local write data.
- `loc_ack` out 1: one-cycle completion pulse.
- `loc_err` out 1: valid with `loc_ack`; set for unmapped or read-only writes.
- `loc_rdata` out 8: local read data, valid with `loc_ack`.
- `i2c_wr_evt` out 1: one-cycle pulse after an I2C write to a RW register commits.
- `i2c_wr_addr` out 8: address of the last committed I2C RW write.
- `cfg_out` out `8*NUM_REGS`: flat register contents. Register k occupies bits `[8k+7:8k]`.

## Operation

**Register map**

- 0x00 `ID`: read-only, returns `ID_VALUE`.
- 0x01 `COLL_CNT`: read-only from the local port. Any I2C write to 0x01 clears it to 0x00, regardless of data.
- 0x02..`NUM_REGS-1`: RW, reset value 0x00.
- Unmapped addresses read 0xFF. Writes to unmapped addresses are dropped.

**I2C port**

- `i2c_rdata` is a pure combinational decode of `i2c_addr` and current register state. The slave samples it in the same cycle as `i2c_rd`.
- `i2c_wr` commits at the same rising edge; no stall is possible.
- I2C writes to 0x00 or to unmapped addresses are dropped silently and produce no `i2c_wr_evt`.

**Local port FSM**

- States: `L_IDLE`, `L_ACK`.
- `L_IDLE`, `loc_req=1`, `i2c_wr=0`: the access executes at this edge and the FSM moves to `L_ACK`.
  - Write: committed if the address is RW.
  - Read: the register value is captured into `loc_rdata`.
  - `loc_err` is set if the address is unmapped, or if this is a write to 0x00/0x01.
- `L_IDLE`, `loc_req=1`, `i2c_wr=1`: collision. The local access is not accepted. `COLL_CNT` increments, saturating at 0xFF. The FSM stays in `L_IDLE`.
- `L_ACK`: `loc_ack=1` for exactly this cycle, then unconditional return to `L_IDLE`.
  - A `loc_req` still high in the following `L_IDLE` cycle starts a new transaction.
  - The requester must drop `loc_req` in the cycle it sees `loc_ack`.
- Local and I2C writes to the same register are never applied in the same cycle. The local write lands at least one cycle later, so the final value is the local data.
- Same-cycle I2C write to 0x01 and a collision increment: the clear dominates, `COLL_CNT = 0x00`.

**Reset values**

- All RW registers and `COLL_CNT`: 0x00.
- `loc_ack`, `loc_err`, `i2c_wr_evt`: 0.
- `loc_rdata`, `i2c_wr_addr`: 0x00.
- FSM: `L_IDLE`.
- `cfg_out`: reg0 = `ID_VALUE`, all others 0.
- Reset asserted during `L_ACK` cancels the pending ack; `loc_ack=0` in the next cycle.

## Timing

- I2C read latency: 0 cycles, combinational.
- I2C write: visible on `i2c_rdata` and `cfg_out` one cycle after the strobe cycle. `i2c_wr_evt` and `i2c_wr_addr` are registered and valid in that same following cycle.
- Local access: `loc_req` sampled at edge N with no collision → `loc_ack`, `loc_err` and `loc_rdata` valid during cycle N+1.
- Minimum local period is 2 cycles per access. Each collision adds 1 cycle.
- `cfg_out` is driven directly from the registers, with no additional latency.

## Test plan

- **Reset.** Assert `rst` for 2 cycles, then read I2C addr 0x00, 0x01, 0x05 → 0xA5, 0x00, 0x00; `loc_ack=0`.
- **I2C write/read.** I2C write 0x3C to 0x04 → `i2c_rdata`=0x3C the next cycle, `i2c_wr_evt` pulses one cycle with `i2c_wr_addr`=0x04, `cfg_out[39:32]`=0x3C.
- **Collision.** Hold `loc_req` with write 0x77 to 0x04 while `i2c_wr` writes 0x11 to 0x04 in the same cycle → ack is delayed 1 cycle, final reg 0x04 = 0x77, `COLL_CNT` = 0x01. An I2C write 0x00 to 0x01 then → `COLL_CNT` = 0x00.
- **Error cases.**
  - Local write to 0x00 → ack with `loc_err=1`, ID still 0xA5.
  - Local read of 0x20 with `NUM_REGS=16` → `loc_rdata`=0xFF, `loc_err=1`.
- **Saturation.** Force 300 consecutive collisions → `COLL_CNT` = 0xFF.
- **Back-to-back and reset.**
  - Back-to-back local reads of 0x02 and 0x03 → acks 2 cycles apart.
  - `rst` asserted in the `L_ACK` cycle → no ack next cycle, registers at reset values.

Source files
------------

// File: rtl/i2c_regbank_arbiter_if.sv
// Bus bundle between the I2C slave / local requester and the shared register bank.
// The master modport is the access side; the slave modport is the bank.
interface i2c_regbank_arbiter_if;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_wr;
  logic       i2c_rd;
  logic [7:0] i2c_rdata;
  logic [7:0] i2c_wr_addr;
  logic       i2c_wr_evt;
  logic       loc_req;
  logic       loc_we;
  logic [7:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_ack;
  logic       loc_err;
  logic [7:0] loc_rdata;

  modport master (
    output i2c_addr, i2c_wdata, i2c_wr, i2c_rd,
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  i2c_rdata, i2c_wr_evt, i2c_wr_addr,
    input  loc_ack, loc_err, loc_rdata
  );

  modport slave (
    input  i2c_addr, i2c_wdata, i2c_wr, i2c_rd,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output i2c_rdata, i2c_wr_evt, i2c_wr_addr,
    output loc_ack, loc_err, loc_rdata
  );
endinterface

// File: rtl/i2c_regbank_arbiter.sv
// 8-bit register bank shared by a zero-wait I2C strobe port and a req/ack local port.
// I2C always wins; a colliding local request is deferred and counted in COLL_CNT.
module i2c_regbank_arbiter #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  i2c_regbank_arbiter_if.slave    bus,
  output logic [8*NUM_REGS-1:0]   cfg_out
);

  localparam logic [8:0] NREGS9 = 9'(NUM_REGS);

  typedef enum logic {L_IDLE, L_ACK} lstate_t;

  lstate_t    state, state_nxt;
  logic [7:0] coll_cnt;
  logic [7:0] rw_q [2:NUM_REGS-1];
  logic       loc_take_c, loc_coll_c, loc_wr_c, i2c_rw_c;
  logic [7:0] loc_rd_c;
  logic       unused_rd;

  assign unused_rd = bus.i2c_rd;

  function automatic logic is_mapped(input logic [7:0] a);
    return {1'b0, a} < NREGS9;
  endfunction

  function automatic logic is_rw(input logic [7:0] a);
    return (a >= 8'd2) && is_mapped(a);
  endfunction

  function automatic logic [7:0] read_reg(input logic [7:0] a);
    logic [7:0] v;
    v = 8'hFF;
    if (a == 8'd0) v = ID_VALUE;
    else if (a == 8'd1) v = coll_cnt;
    for (int unsigned k = 2; k < NUM_REGS; k++)
      if (a == 8'(k)) v = rw_q[k];
    return v;
  endfunction

  // Read decode for both ports
  always_comb begin
    bus.i2c_rdata = read_reg(bus.i2c_addr);
    loc_rd_c      = read_reg(bus.loc_addr);
  end

  assign i2c_rw_c = bus.i2c_wr && is_rw(bus.i2c_addr);
  assign loc_wr_c = loc_take_c && bus.loc_we && is_rw(bus.loc_addr);

  always_ff @(posedge clk) begin
    if (rst) state <= L_IDLE;
    else     state <= state_nxt;
  end

  // Local port: accept when no I2C write is in flight, else count a collision
  always_comb begin
    state_nxt  = state;
    loc_take_c = 1'b0;
    loc_coll_c = 1'b0;
    case (state)
      L_IDLE: begin
        if (bus.loc_req) begin
          if (bus.i2c_wr) begin
            loc_coll_c = 1'b1;
          end else begin
            loc_take_c = 1'b1;
            state_nxt  = L_ACK;
          end
        end
      end
      L_ACK:   state_nxt = L_IDLE;
      default: state_nxt = L_IDLE;
    endcase
  end

  assign bus.loc_ack = (state == L_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.loc_err     <= 1'b0;
      bus.loc_rdata   <= 8'h00;
      bus.i2c_wr_evt  <= 1'b0;
      bus.i2c_wr_addr <= 8'h00;
    end else begin
      bus.i2c_wr_evt <= i2c_rw_c;
      if (i2c_rw_c) bus.i2c_wr_addr <= bus.i2c_addr;
      if (loc_take_c) begin
        bus.loc_err <= !is_mapped(bus.loc_addr) || (bus.loc_we && (bus.loc_addr < 8'd2));
        if (!bus.loc_we) bus.loc_rdata <= loc_rd_c;
      end
    end
  end

  // I2C clear of COLL_CNT dominates a same-cycle collision increment
  always_ff @(posedge clk) begin
    if (rst)                                      coll_cnt <= 8'h00;
    else if (bus.i2c_wr && bus.i2c_addr == 8'd1)  coll_cnt <= 8'h00;
    else if (loc_coll_c && coll_cnt != 8'hFF)     coll_cnt <= coll_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 2; k < NUM_REGS; k++) rw_q[k] <= 8'h00;
    end else begin
      for (int unsigned k = 2; k < NUM_REGS; k++) begin
        if (i2c_rw_c && bus.i2c_addr == 8'(k))      rw_q[k] <= bus.i2c_wdata;
        else if (loc_wr_c && bus.loc_addr == 8'(k)) rw_q[k] <= bus.loc_wdata;
      end
    end
  end

  always_comb begin
    cfg_out       = '0;
    cfg_out[7:0]  = ID_VALUE;
    cfg_out[15:8] = coll_cnt;
    for (int unsigned k = 2; k < NUM_REGS; k++) cfg_out[8*k +: 8] = rw_q[k];
  end

endmodule

// File: tb/tb_i2c_regbank_arbiter.sv
// Randomized bench for i2c_regbank_arbiter against an array-based behavioural model,
// preceded by directed scenarios with hand-computed expectations.
module tb_i2c_regbank_arbiter;
  localparam int         N  = 16;
  localparam logic [7:0] ID = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_regbank_arbiter_if bus();
  logic [8*N-1:0] cfg_out;

  i2c_regbank_arbiter #(.NUM_REGS(N), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cfg_out(cfg_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model state
  logic [7:0] m_rw [256];
  logic [7:0] m_coll, m_rdata, m_waddr;
  bit         m_ack, m_err, m_isrd, m_evt, mvalid;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mread(input logic [7:0] a);
    if (a == 8'd0) return ID;
    if (a == 8'd1) return m_coll;
    if (int'(a) < N) return m_rw[a];
    return 8'hFF;
  endfunction

  function automatic logic [127:0] mcfg();
    logic [127:0] v;
    for (int k = 0; k < N; k++) v[8*k +: 8] = mread(8'(k));
    return v;
  endfunction

  function automatic logic [7:0] raddr();
    int r;
    r = $urandom_range(0, 7);
    if (r < 6)  return 8'($urandom_range(0, N - 1));
    if (r == 6) return 8'($urandom_range(N, 255));
    return 8'd1;
  endfunction

  // Model: one update per rising edge from the driven inputs
  always @(posedge clk) begin
    logic [7:0] a;
    cyc++;
    if (rst) begin
      for (int k = 0; k < 256; k++) m_rw[k] = 8'h00;
      m_coll = 8'h00; m_ack = 1'b0; m_err = 1'b0; m_isrd = 1'b0;
      m_rdata = 8'h00; m_evt = 1'b0; m_waddr = 8'h00; mvalid = 1'b1;
    end else begin
      a = bus.loc_addr;
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (bus.loc_req) begin
        if (bus.i2c_wr) begin
          if (m_coll != 8'hFF) m_coll = m_coll + 8'd1;
        end else begin
          m_ack  = 1'b1;
          m_err  = (int'(a) >= N) || (bus.loc_we && a < 8'd2);
          m_isrd = !bus.loc_we;
          if (!bus.loc_we) m_rdata = mread(a);
          if (bus.loc_we && a >= 8'd2 && int'(a) < N) m_rw[a] = bus.loc_wdata;
        end
      end
      m_evt = 1'b0;
      if (bus.i2c_wr) begin
        if (bus.i2c_addr == 8'd1) m_coll = 8'h00;
        else if (bus.i2c_addr >= 8'd2 && int'(bus.i2c_addr) < N) begin
          m_rw[bus.i2c_addr] = bus.i2c_wdata;
          m_evt   = 1'b1;
          m_waddr = bus.i2c_addr;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (mvalid) begin
      chk("i2c_rdata", 128'(bus.i2c_rdata), 128'(mread(bus.i2c_addr)));
      chk("cfg_out", 128'(cfg_out), mcfg());
      chk("loc_ack", 128'(bus.loc_ack), 128'(m_ack));
      if (m_ack) chk("loc_err", 128'(bus.loc_err), 128'(m_err));
      if (m_ack && m_isrd) chk("loc_rdata", 128'(bus.loc_rdata), 128'(m_rdata));
      chk("i2c_wr_evt", 128'(bus.i2c_wr_evt), 128'(m_evt));
      chk("i2c_wr_addr", 128'(bus.i2c_wr_addr), 128'(m_waddr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loc_do(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        output logic err, output logic [7:0] rd, output int t);
    step();
    bus.loc_req = 1'b1; bus.loc_we = we; bus.loc_addr = addr; bus.loc_wdata = wd;
    t = -1; err = 1'b0; rd = 8'h00;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bus.loc_ack) begin
        t = cyc;
        bus.loc_req = 1'b0;
        @(negedge clk);
        err = bus.loc_err;
        rd  = bus.loc_rdata;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL loc_timeout: no ack for addr %0h within 400 cycles", addr);
    bus.loc_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       e;
    logic [7:0] r;
    int         t1, t2, pend;

    bus.i2c_addr = 8'h00; bus.i2c_wdata = 8'h00; bus.i2c_wr = 1'b0; bus.i2c_rd = 1'b0;
    bus.loc_req = 1'b0; bus.loc_we = 1'b0; bus.loc_addr = 8'h00; bus.loc_wdata = 8'h00;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    bus.i2c_addr = 8'h00; #1 chk("rst_id", 128'(bus.i2c_rdata), 128'hA5);
    bus.i2c_addr = 8'h01; #1 chk("rst_coll", 128'(bus.i2c_rdata), 128'h00);
    bus.i2c_addr = 8'h05; #1 chk("rst_r5", 128'(bus.i2c_rdata), 128'h00);
    chk("rst_ack", 128'(bus.loc_ack), 128'h0);
    chk("rst_cfg", 128'(cfg_out), 128'hA5);

    // I2C write then readback
    step();
    bus.i2c_wr = 1'b1; bus.i2c_addr = 8'h04; bus.i2c_wdata = 8'h3C;
    step();
    bus.i2c_wr = 1'b0;
    @(negedge clk);
    chk("wr_rdata", 128'(bus.i2c_rdata), 128'h3C);
    chk("wr_evt", 128'(bus.i2c_wr_evt), 128'h1);
    chk("wr_addr", 128'(bus.i2c_wr_addr), 128'h04);
    chk("wr_cfg4", 128'(cfg_out[39:32]), 128'h3C);
    step();
    @(negedge clk);
    chk("wr_evt_one", 128'(bus.i2c_wr_evt), 128'h0);

    // Collision: I2C wins, local write lands a cycle later
    step();
    bus.loc_req = 1'b1; bus.loc_we = 1'b1; bus.loc_addr = 8'h04; bus.loc_wdata = 8'h77;
    bus.i2c_wr = 1'b1; bus.i2c_addr = 8'h04; bus.i2c_wdata = 8'h11;
    step();
    bus.i2c_wr = 1'b0;
    @(negedge clk);
    chk("coll_noack", 128'(bus.loc_ack), 128'h0);
    chk("coll_i2c_val", 128'(bus.i2c_rdata), 128'h11);
    chk("coll_cnt1", 128'(cfg_out[15:8]), 128'h01);
    step();
    if (bus.loc_ack) bus.loc_req = 1'b0;
    @(negedge clk);
    chk("coll_ack", 128'(bus.loc_ack), 128'h1);
    chk("coll_err", 128'(bus.loc_err), 128'h0);
    bus.loc_req = 1'b0;
    step();
    @(negedge clk);
    chk("coll_final", 128'(bus.i2c_rdata), 128'h77);
    step();
    bus.i2c_wr = 1'b1; bus.i2c_addr = 8'h01; bus.i2c_wdata = 8'h00;
    step();
    bus.i2c_wr = 1'b0;
    @(negedge clk);
    chk("coll_clear", 128'(bus.i2c_rdata), 128'h00);

    // Error cases
    loc_do(1'b1, 8'h00, 8'h12, e, r, t1);
    chk("err_wr_id", 128'(e), 128'h1);
    bus.i2c_addr = 8'h00; #1 chk("id_kept", 128'(bus.i2c_rdata), 128'hA5);
    loc_do(1'b0, 8'h20, 8'h00, e, r, t1);
    chk("err_unmapped", 128'(e), 128'h1);
    chk("unmapped_rd", 128'(r), 128'hFF);

    // Saturation: 300 consecutive collisions
    step();
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h02;
    bus.i2c_wr = 1'b1; bus.i2c_addr = 8'h05; bus.i2c_wdata = 8'($urandom);
    repeat (299) begin
      step();
      bus.i2c_wdata = 8'($urandom);
    end
    step();
    bus.i2c_wr = 1'b0; bus.i2c_addr = 8'h01;
    @(negedge clk);
    chk("sat_coll", 128'(bus.i2c_rdata), 128'hFF);
    chk("sat_noack", 128'(bus.loc_ack), 128'h0);
    step();
    if (bus.loc_ack) bus.loc_req = 1'b0;
    @(negedge clk);
    chk("sat_ack", 128'(bus.loc_ack), 128'h1);
    bus.loc_req = 1'b0;

    // Back-to-back local reads
    loc_do(1'b0, 8'h02, 8'h00, e, r, t1);
    loc_do(1'b0, 8'h03, 8'h00, e, r, t2);
    chk("b2b_gap", 128'(t2 - t1), 128'd2);

    // Reset during the ack cycle
    loc_do(1'b1, 8'h06, 8'h55, e, r, t1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i2c_addr = 8'h06;
    @(negedge clk);
    chk("rst_ack_cancel", 128'(bus.loc_ack), 128'h0);
    chk("rst_r6", 128'(bus.i2c_rdata), 128'h00);
    chk("rst_cfg2", 128'(cfg_out), 128'hA5);

    // Randomized traffic on both ports
    pend = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      bus.i2c_wr    = ($urandom_range(0, 3) == 0);
      bus.i2c_addr  = raddr();
      bus.i2c_wdata = 8'($urandom);
      bus.i2c_rd    = 1'($urandom_range(0, 1));
      if (bus.loc_req) begin
        if (bus.loc_ack) begin
          bus.loc_req = 1'b0;
          pend = 0;
        end else begin
          pend++;
          if (pend > 40) begin
            checks++; errors++;
            $display("FAIL rand_loc_timeout: request pending %0d cycles", pend);
            bus.loc_req = 1'b0;
            pend = 0;
          end
        end
      end else if ($urandom_range(0, 1) == 1) begin
        bus.loc_req   = 1'b1;
        bus.loc_we    = 1'($urandom_range(0, 1));
        bus.loc_addr  = raddr();
        bus.loc_wdata = 8'($urandom);
        pend = 0;
      end
    end

    step();
    bus.loc_req = 1'b0; bus.i2c_wr = 1'b0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
